// File: rtl/reg_16bit_reader_pkg.sv
// rtl/reg_16bit_reader_pkg.sv - shared state encodings and clear pattern for the 16-bit register family
package reg_16bit_reader_pkg;

  localparam int REG_WIDTH = 16;

  // Power-on pattern of the PC/flag registers: bits 9,7,6,5,0 clear to 1.
  localparam logic [REG_WIDTH-1:0] CLEAR_VAL_DEFAULT = 16'h02E1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } rd_state_e;

endpackage

// File: rtl/reg_16bit_reader_piso_shift.sv
// rtl/reg_16bit_reader_piso_shift.sv - parallel-load shift register feeding the serial output
module reg_16bit_reader_piso_shift #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  // Load has priority over shift; vacated positions fill with zero.
  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = din;
    end else if (shift) begin
      if (MSB_FIRST) begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      end else begin
        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign sout = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

endmodule

// File: rtl/reg_16bit_reader.sv
// rtl/reg_16bit_reader.sv - snapshots a register on start and dumps it serially over valid/ready
module reg_16bit_reader
  import reg_16bit_reader_pkg::*;
#(
  parameter int               WIDTH     = REG_WIDTH,
  parameter logic [WIDTH-1:0] CLEAR_VAL = WIDTH'(CLEAR_VAL_DEFAULT),
  parameter bit               MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             Clear,
  input  logic             start,
  input  logic [WIDTH-1:0] REG_IN,
  output logic             SOUT,
  output logic             SVALID,
  input  logic             SREADY,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] SNAP,
  output logic             AT_CLEAR
);

  localparam int               CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  rd_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] snap_q, snap_d;
  logic             at_clear_q, at_clear_d;
  logic             load, shift;
  logic             shreg_bit;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    snap_d     = snap_q;
    at_clear_d = at_clear_q;
    load       = 1'b0;
    shift      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SHIFT;
          load       = 1'b1;
          snap_d     = REG_IN;
          at_clear_d = (REG_IN == CLEAR_VAL);
          cnt_d      = '0;
        end
      end
      ST_SHIFT: begin
        if (SREADY) begin
          shift = 1'b1;
          // Leave on the last bit instead of incrementing so cnt never wraps.
          if (cnt_q == CNT_MAX) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (Clear) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      snap_q     <= '0;
      at_clear_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
      at_clear_q <= at_clear_d;
    end
  end

  reg_16bit_reader_piso_shift #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk   (clk),
    .clr   (Clear),
    .load  (load),
    .shift (shift),
    .din   (REG_IN),
    .sout  (shreg_bit)
  );

  assign SVALID   = (state_q == ST_SHIFT);
  assign SOUT     = SVALID & shreg_bit;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign SNAP     = snap_q;
  assign AT_CLEAR = at_clear_q;

endmodule

// File: tb/tb_reg_16bit_reader.sv
// tb/tb_reg_16bit_reader.sv - checks MSB-first and LSB-first builds against a bit-count reference model
module tb_reg_16bit_reader;

  logic        clk = 1'b0;
  logic        Clear, start, SREADY;
  logic [15:0] REG_IN;

  logic        sout_m, svalid_m, busy_m, done_m, at_m;
  logic [15:0] snap_m;
  logic        sout_l, svalid_l, busy_l, done_l, at_l;
  logic [15:0] snap_l;

  always #5 clk = ~clk;

  reg_16bit_reader #(.MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .Clear(Clear), .start(start), .REG_IN(REG_IN),
    .SOUT(sout_m), .SVALID(svalid_m), .SREADY(SREADY), .busy(busy_m),
    .done(done_m), .SNAP(snap_m), .AT_CLEAR(at_m)
  );

  reg_16bit_reader #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .Clear(Clear), .start(start), .REG_IN(REG_IN),
    .SOUT(sout_l), .SVALID(svalid_l), .SREADY(SREADY), .busy(busy_l),
    .done(done_l), .SNAP(snap_l), .AT_CLEAR(at_l)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: bits still owed, captured value, pending done pulse.
  int          rem     = 0;
  logic [15:0] r_snap  = '0;
  logic        r_atc   = 1'b0;
  logic        r_done  = 1'b0;

  int          xfers;
  int          dones;
  logic [15:0] str_m, str_l;

  typedef struct {
    logic [15:0] val;
    logic [15:0] exp_msb;
    logic [15:0] exp_lsb;
    logic        exp_atc;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    if (Clear) begin
      rem = 0; r_snap = '0; r_atc = 1'b0; r_done = 1'b0;
    end else if (r_done) begin
      r_done = 1'b0;
    end else if (rem > 0) begin
      if (SREADY) begin
        rem--;
        if (rem == 0) r_done = 1'b1;
      end
    end else if (start) begin
      rem    = 16;
      r_snap = REG_IN;
      r_atc  = (REG_IN == 16'h02E1);
    end
  endtask

  task automatic check_model();
    logic e_sm, e_sl, e_sv;
    int   idx;
    e_sm = 1'b0; e_sl = 1'b0;
    e_sv = (rem > 0);
    idx  = 16 - rem;
    if (rem > 0) begin
      e_sm = r_snap[15-idx];
      e_sl = r_snap[idx];
    end
    chk("svalid_msb", svalid_m, e_sv);
    chk("svalid_lsb", svalid_l, e_sv);
    chk("sout_msb",   sout_m,   e_sm);
    chk("sout_lsb",   sout_l,   e_sl);
    chk("busy_msb",   busy_m,   e_sv | r_done);
    chk("busy_lsb",   busy_l,   e_sv | r_done);
    chk("done_msb",   done_m,   r_done);
    chk("done_lsb",   done_l,   r_done);
    chk("snap_msb",   snap_m,   r_snap);
    chk("snap_lsb",   snap_l,   r_snap);
    chk("atclr_msb",  at_m,     r_atc);
    chk("atclr_lsb",  at_l,     r_atc);
  endtask

  // One clock: log the bit about to transfer, advance DUT and model, compare.
  task automatic cycle();
    if (svalid_m === 1'b1 && SREADY) begin
      xfers++;
      str_m = {str_m[14:0], sout_m};
      str_l = {sout_l, str_l[15:1]};
    end
    @(posedge clk);
    model_step();
    #1;
    if (done_m === 1'b1) dones++;
    check_model();
  endtask

  task automatic clr_capture();
    xfers = 0; dones = 0; str_m = '0; str_l = '0;
  endtask

  task automatic run_dump(input logic [15:0] v, output int done_at);
    clr_capture();
    REG_IN = v; start = 1'b1;
    cycle();
    start = 1'b0;
    done_at = -1;
    for (int k = 1; k <= 40; k++) begin
      cycle();
      if (done_m === 1'b1 && done_at < 0) done_at = k;
      if (busy_m !== 1'b1) break;
    end
  endtask

  initial begin
    int          done_at;
    logic [3:0]  pat;

    vecs[0] = '{16'hA5C3, 16'b1010_0101_1100_0011, 16'hA5C3, 1'b0};
    vecs[1] = '{16'h02E1, 16'b0000_0010_1110_0001, 16'h02E1, 1'b1};
    vecs[2] = '{16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0};
    vecs[4] = '{16'h02E0, 16'h02E0, 16'h02E0, 1'b0};

    // Reset with start held: nothing may begin.
    Clear = 1'b1; start = 1'b1; REG_IN = 16'hA5C3; SREADY = 1'b1;
    clr_capture();
    cycle();
    cycle();
    chk("rst_busy", busy_m, 1'b0);
    chk("rst_snap", snap_m, 16'h0000);
    Clear = 1'b0; start = 1'b0;
    cycle();
    chk("rst_no_dump", svalid_m, 1'b0);

    // Table-driven full dumps with SREADY tied high.
    SREADY = 1'b1;
    foreach (vecs[i]) begin
      run_dump(vecs[i].val, done_at);
      chk("tbl_stream_msb", str_m, vecs[i].exp_msb);
      chk("tbl_stream_lsb", str_l, vecs[i].exp_lsb);
      chk("tbl_first8_lsb", str_l[7:0], vecs[i].exp_lsb[7:0]);
      chk("tbl_atclr", at_m, vecs[i].exp_atc);
      chk("tbl_snap", snap_m, vecs[i].val);
      chk("tbl_done_at", done_at, 16);
      chk("tbl_dones", dones, 1);
      chk("tbl_xfers", xfers, 16);
      chk("tbl_idle_after", busy_m, 1'b0);
    end

    // Back-pressure pattern 1,0,0,1.
    pat = 4'b1001;
    clr_capture();
    REG_IN = 16'h5A3C; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      SREADY = pat[3 - (k % 4)];
      cycle();
      if (busy_m !== 1'b1) break;
    end
    chk("bp_xfers", xfers, 16);
    chk("bp_dones", dones, 1);
    chk("bp_stream", str_m, 16'h5A3C);
    chk("bp_stream_lsb", str_l, 16'h5A3C);

    // Re-start and REG_IN change mid-dump are ignored.
    SREADY = 1'b1;
    clr_capture();
    REG_IN = 16'h3C5A; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int k = 0; k < 5; k++) cycle();
    start = 1'b1; REG_IN = 16'hFFFF;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (done_m === 1'b1) start = 1'b0;
      if (busy_m !== 1'b1) break;
    end
    start = 1'b0;
    chk("mid_stream", str_m, 16'h3C5A);
    chk("mid_snap", snap_m, 16'h3C5A);
    chk("mid_dones", dones, 1);
    cycle();

    // Clear after the 7th transfer abandons the dump.
    clr_capture();
    REG_IN = 16'h0F0F; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int k = 0; k < 7; k++) cycle();
    chk("abort_xfers", xfers, 7);
    Clear = 1'b1;
    cycle();
    chk("abort_svalid", svalid_m, 1'b0);
    chk("abort_busy", busy_m, 1'b0);
    chk("abort_snap", snap_m, 16'h0000);
    Clear = 1'b0;
    for (int k = 0; k < 20; k++) cycle();
    chk("abort_no_done", dones, 0);
    run_dump(16'h8001, done_at);
    chk("abort_restart", str_m, 16'h8001);
    chk("abort_restart_done", done_at, 16);

    // Randomized traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      Clear  = ($urandom_range(0, 59) == 0);
      start  = ($urandom_range(0, 3) == 0);
      REG_IN = ($urandom_range(0, 4) == 0) ? 16'h02E1 : 16'($urandom);
      SREADY = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
